// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity helper.
// Used by both the transmitter and the receiver so state dumps decode the same way.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, optional parity, 1 or 2 stop bits; 1-byte holding register.
// Latency: frame starts on the first baud_tick after accept; tx_ready drops while the holding register is full.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic ODD       = (PARITY_ODD != 0);
    localparam logic USE_PAR   = (PARITY_EN != 0);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic [7:0] shreg;
    logic [7:0] hold_reg;
    logic       hold_full;

    assign tx_ready = !hold_full;
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            shreg     <= 8'd0;
            hold_reg  <= 8'd0;
            hold_full <= 1'b0;
            tx_line   <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Accept and load never coincide: accept needs the holding register empty, load needs it full.
            if (tx_valid && !hold_full) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
            end

            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        tx_line <= 1'b1;
                        if (hold_full) begin
                            shreg     <= hold_reg;
                            hold_full <= 1'b0;
                            tx_line   <= 1'b0;
                            state     <= START;
                        end
                    end
                    START: begin
                        tx_line <= shreg[0];
                        bit_cnt <= 3'd0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt  <= 3'd0;
                            stop_cnt <= 1'b0;
                            if (USE_PAR) begin
                                tx_line <= parity_of(shreg, ODD);
                                state   <= PARITY;
                            end else begin
                                tx_line <= 1'b1;
                                state   <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_line <= shreg[bit_cnt + 3'd1];
                        end
                    end
                    PARITY: begin
                        tx_line  <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_done  <= 1'b1;
                            stop_cnt <= 1'b0;
                            // A pending byte starts immediately, with no idle bit between frames.
                            if (hold_full) begin
                                shreg     <= hold_reg;
                                hold_full <= 1'b0;
                                tx_line   <= 1'b0;
                                state     <= START;
                            end else begin
                                tx_line <= 1'b1;
                                state   <= IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        tx_line <= 1'b1;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameter variants share one stimulus bus, each test checks one of them.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic [3:0] ready_w, line_w, busy_w, done_w;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits
    uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[0]), .tx_line(line_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[1]), .tx_line(line_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[2]), .tx_line(line_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_w[3]), .tx_line(line_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] data;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge, outputs are sampled there too.
    task automatic cyc(input logic tk);
        baud_tick = tk;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
    endtask

    // Called right after the tick that starts a frame. exp holds the line level per interval, in time order.
    task automatic play(input int d, input string exp, input int exp_done, input int drop_after);
        int done_cnt = 0;
        int done_at = -1;
        int unstable = 0;
        int ncyc = 0;
        logic lv;
        for (int k = 0; k < exp.len(); k++) begin
            lv = line_w[d];
            chk($sformatf("dut%0d line interval %0d", d, k), int'(lv), (exp[k] == 8'd49) ? 1 : 0);
            for (int c = 0; c < 16; c++) begin
                cyc(c == 15);
                ncyc++;
                if (ncyc == drop_after) tx_valid = 1'b0;
                if (c != 15 && line_w[d] != lv) unstable++;
                if (done_w[d]) begin
                    done_cnt++;
                    done_at = k;
                    if (c != 15) unstable++;
                end
            end
        end
        chk($sformatf("dut%0d mid-interval glitches", d), unstable, 0);
        chk($sformatf("dut%0d tx_done count", d), done_cnt, exp_done);
        chk($sformatf("dut%0d last tx_done interval", d), done_at, exp.len() - 1);
        chk($sformatf("dut%0d idle line after frame", d), int'(line_w[d]), 1);
        chk($sformatf("dut%0d busy after frame", d), int'(busy_w[d]), 0);
    endtask

    vec_t  tab [7];
    string tab_exp [7];

    initial begin
        int bad;

        tab[0] = '{dut: 2'd0, data: 8'hA5}; tab_exp[0] = "0101001011";
        tab[1] = '{dut: 2'd0, data: 8'h3C}; tab_exp[1] = "0001111001";
        tab[2] = '{dut: 2'd1, data: 8'h07}; tab_exp[2] = "01110000011";
        tab[3] = '{dut: 2'd2, data: 8'h07}; tab_exp[3] = "01110000001";
        tab[4] = '{dut: 2'd3, data: 8'h55}; tab_exp[4] = "01010101011";
        tab[5] = '{dut: 2'd1, data: 8'h80}; tab_exp[5] = "00000000111";
        tab[6] = '{dut: 2'd2, data: 8'h00}; tab_exp[6] = "00000000011";

        #1;
        do_reset();
        chk("reset tx_line", int'(line_w[0]), 1);
        chk("reset tx_ready", int'(ready_w[0]), 1);
        chk("reset tx_busy", int'(busy_w[0]), 0);
        chk("reset tx_done", int'(done_w[0]), 0);

        // Single frames; the accept lands one clk before the starting tick, so tx_ready is low for 1 clk.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            tx_data  = tab[i].data;
            tx_valid = 1'b1;
            cyc(1'b0);
            tx_valid = 1'b0;
            chk($sformatf("vec%0d tx_ready after accept", i), int'(ready_w[tab[i].dut]), 0);
            cyc(1'b1);
            chk($sformatf("vec%0d tx_ready after load", i), int'(ready_w[tab[i].dut]), 1);
            chk($sformatf("vec%0d tx_busy in frame", i), int'(busy_w[tab[i].dut]), 1);
            play(int'(tab[i].dut), tab_exp[i], 1, -1);
        end

        // Back-to-back: 0xFF accepted while 0x00 is on the line, no idle bit between frames.
        do_reset();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        cyc(1'b0);
        tx_valid = 1'b0;
        cyc(1'b1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        play(0, "00000000010111111111", 2, 1);

        // Holding register is never overwritten; with no ticks nothing moves.
        do_reset();
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        cyc(1'b0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tx_data = 8'(c * 37 + 5);
            cyc(1'b0);
            if (line_w[0] != 1'b1 || busy_w[0] != 1'b0 || ready_w[0] != 1'b0 || done_w[0] != 1'b0) bad++;
        end
        chk("no-tick hold cycles off", bad, 0);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        cyc(1'b1);
        play(0, "0100010001", 1, -1);

        // Reset in DATA bit 3 with a byte pending; tx_valid during reset is ignored.
        do_reset();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        cyc(1'b0);
        tx_valid = 1'b0;
        cyc(1'b1);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        cyc(1'b0);
        tx_valid = 1'b0;
        chk("pending byte held", int'(ready_w[0]), 0);
        for (int c = 1; c < 64; c++) cyc((c % 16) == 15);
        chk("line at data bit 3", int'(line_w[0]), 1);
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        cyc(1'b0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        chk("mid-frame reset tx_line", int'(line_w[0]), 1);
        chk("mid-frame reset tx_ready", int'(ready_w[0]), 1);
        chk("mid-frame reset tx_busy", int'(busy_w[0]), 0);
        chk("mid-frame reset tx_done", int'(done_w[0]), 0);
        bad = 0;
        for (int c = 0; c < 16 * 14; c++) begin
            cyc((c % 16) == 15);
            if (line_w[0] != 1'b1 || busy_w[0] != 1'b0 || done_w[0] != 1'b0) bad++;
        end
        chk("aborted frame stays silent", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0: 1 = insert a parity bit after data bit 7.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-003 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset; one clock, synchronous, active-high.
REQ-006 SHALL have port baud_tick, input, 1: one-clk strobe, once per bit period.
REQ-007 SHALL have port tx_data, input, 8: byte to send.
REQ-008 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-009 SHALL have port tx_ready, output, 1: holding register empty, so the byte can be accepted.
REQ-010 SHALL have port tx_line, output, 1: UART serial output, idle high.
REQ-011 SHALL have port tx_busy, output, 1: a frame is on the line (state not IDLE).
REQ-012 SHALL have port tx_done, output, 1: one-clk pulse when a frame's last stop bit ends.

Function
REQ-013 SHALL accept a byte on any clk edge where tx_valid && tx_ready, loading it into a 1-entry holding register; tx_ready = !hold_full, combinational from the flag.
REQ-014 SHALL ignore tx_data and tx_valid while tx_ready=0; the holding register content is never overwritten.
REQ-015 SHALL hold state, bit counter and tx_line unless baud_tick=1; all frame transitions occur only on baud_tick edges.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: tx_line=1; on baud_tick with hold_full=1, the byte moves to the shift register, hold_full clears, tx_line<=0 and state goes to START.
REQ-018 START -> DATA on baud_tick: tx_line<=bit0 and bit_cnt<=0; the start bit lasts exactly one tick interval.
REQ-019 DATA: each baud_tick sends the next bit, LSB first; after bit 7 the next state is PARITY if PARITY_EN=1, else STOP (tx_line<=1).
REQ-020 PARITY: tx_line = XOR of the 8 data bits, inverted if PARITY_ODD=1; the next baud_tick goes to STOP with tx_line<=1.
REQ-021 STOP: tx_line=1 for STOP_BITS tick intervals; the baud_tick ending the last stop bit asserts tx_done for that one clk.
REQ-022 At the end of the last stop bit, if hold_full=1 the block SHALL go directly to START (tx_line<=0, no idle gap); otherwise it goes to IDLE.
REQ-023 An accept and a shift-register load on the same clk SHALL be impossible, because loading requires hold_full=1 and accepting requires hold_full=0. A byte accepted on an IDLE baud_tick edge starts on the following baud_tick.
REQ-024 Frame length SHALL be 1+8+PARITY_EN+STOP_BITS tick intervals.
REQ-025 tx_line SHALL be a registered output, glitch-free.

Reset
REQ-026 rst=1 at a clk edge SHALL force: state=IDLE, tx_line=1, hold_full=0 (tx_ready=1), tx_busy=0, tx_done=0, bit_cnt=0, shift register=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately and discard the held byte; the line returns high on the next edge.
REQ-028 While rst=1, tx_valid SHALL be ignored.

Structure
REQ-029 The state encoding SHALL be 3-bit localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, placed in the shared uart_pkg used by the UART receiver.
REQ-030 The baud_tick generator SHALL be external; no sub-module is required. The holding register and flag SHALL be inline, not a separate FIFO.

Verification
REQ-031 Defaults, send 0xA5 with tick every 16 clk -> tx_line: 0,1,0,1,0,0,1,0,1,1 per tick interval; one tx_done pulse; tx_ready low for 1 clk only.
REQ-032 Two bytes 0x00 then 0xFF offered back-to-back -> second accepted while first is shifting; its start bit immediately follows the stop bit; 20 intervals total, no idle bit.
REQ-033 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> 0; frame is 11 intervals.
REQ-034 STOP_BITS=2, byte 0x55 -> line high for 2 intervals; tx_done on the second interval's ending tick.
REQ-035 rst asserted in the DATA state at bit 3 with a held byte pending -> next clk: tx_line=1, tx_ready=1, tx_busy=0; no tx_done; the pending byte is never sent.
REQ-036 tx_valid held high with hold full for 40 clk, data changing -> only the first value is transmitted; baud_tick tied low -> tx_line stays 1, no state change.
